// File: rtl/adc_readout_pkg.sv
// Shared types and word layout for the AD9228 FIFO readout packer.
// A packed word carries channel tag, word index and two 12-bit samples.
package adc_readout_pkg;

  localparam int PACKED_WIDTH = 32;
  localparam int SAMPLE_WIDTH = 12;

  localparam int CH_ID_MSB     = 31;
  localparam int CH_ID_LSB     = 28;
  localparam int SEQ_MSB       = 27;
  localparam int SEQ_LSB       = 24;
  localparam int SAMPLE_HI_MSB = 23;
  localparam int SAMPLE_HI_LSB = 12;
  localparam int SAMPLE_LO_MSB = 11;
  localparam int SAMPLE_LO_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    CAP_LO,
    RD_HI,
    CAP_HI,
    SEND
  } readout_state_t;

  function automatic logic [PACKED_WIDTH-1:0] pack_word(
    input logic [3:0]              ch,
    input logic [3:0]              seq,
    input logic [SAMPLE_WIDTH-1:0] hi,
    input logic [SAMPLE_WIDTH-1:0] lo
  );
    logic [PACKED_WIDTH-1:0] w;
    w = '0;
    w[CH_ID_MSB:CH_ID_LSB]         = ch;
    w[SEQ_MSB:SEQ_LSB]             = seq;
    w[SAMPLE_HI_MSB:SAMPLE_HI_LSB] = hi;
    w[SAMPLE_LO_MSB:SAMPLE_LO_LSB] = lo;
    return w;
  endfunction

endpackage

// File: rtl/adc_fifo_readout_packer.sv
// Reads one ADC channel's sample FIFO (1-cycle read latency), pairs samples
// into tagged 32-bit words and streams them out in frames with tlast.
module adc_fifo_readout_packer
  import adc_readout_pkg::*;
#(
  parameter int         DATA_WIDTH    = 12,
  parameter logic [3:0] CH_ID         = 4'd0,
  parameter int         FRAME_SAMPLES = 256,
  parameter int         COUNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    fifo_not_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic                    fifo_rd_en,
  output logic [PACKED_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    frame_done,
  output logic [COUNT_WIDTH-1:0]  frame_count
);

  localparam int SCNT_W = $clog2(FRAME_SAMPLES + 1);
  localparam logic [SCNT_W-1:0] LAST_BASE = SCNT_W'(FRAME_SAMPLES - 2);

  generate
    if (FRAME_SAMPLES < 2 || (FRAME_SAMPLES % 2) != 0) begin : g_bad_frame
      $error("FRAME_SAMPLES must be even and at least 2");
    end
    if (DATA_WIDTH != SAMPLE_WIDTH) begin : g_bad_width
      $error("DATA_WIDTH must be 12 to fit the packed word layout");
    end
  endgenerate

  readout_state_t          state_q;
  logic [SCNT_W-1:0]       scnt_q;
  logic [3:0]              seq_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic                    tlast_q;
  logic                    aborted_q;
  logic                    last_pair;
  logic                    abort_end;

  // The word in flight closes the frame when its second sample is the final one.
  assign last_pair = (scnt_q == LAST_BASE);
  assign abort_end = abort || aborted_q;

  // NOTE: the read strobe is combinational so a read issues in the same cycle
  // the FIFO reports data; gating it with fifo_not_empty keeps one read in flight.
  assign fifo_rd_en = ((state_q == RD_LO) || (state_q == RD_HI)) && fifo_not_empty;
  assign busy       = (state_q != IDLE);

  // An abort during SEND marks the pending word as last from that cycle on.
  assign m_tlast    = tlast_q || ((state_q == SEND) && abort);

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // the output word included, is cleared so all outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      seq_q       <= '0;
      lo_q        <= '0;
      tlast_q     <= 1'b0;
      aborted_q   <= 1'b0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q   <= RD_LO;
            scnt_q    <= '0;
            seq_q     <= '0;
            aborted_q <= 1'b0;
          end
        end
        RD_LO: begin
          if (abort)               state_q <= IDLE;
          else if (fifo_not_empty) state_q <= CAP_LO;
        end
        CAP_LO: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            lo_q    <= fifo_dout;
            state_q <= RD_HI;
          end
        end
        RD_HI: begin
          if (abort)               state_q <= IDLE;
          else if (fifo_not_empty) state_q <= CAP_HI;
        end
        CAP_HI: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            m_tdata  <= pack_word(CH_ID, seq_q, fifo_dout, lo_q);
            m_tvalid <= 1'b1;
            tlast_q  <= last_pair;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            aborted_q <= 1'b1;
            tlast_q   <= 1'b1;
          end
          if (m_tready) begin
            m_tvalid <= 1'b0;
            tlast_q  <= 1'b0;
            scnt_q   <= scnt_q + SCNT_W'(2);
            seq_q    <= seq_q + 4'd1;
            if (abort_end || last_pair) begin
              state_q <= IDLE;
              if (!abort_end) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + COUNT_WIDTH'(1);
              end
            end else begin
              state_q <= RD_LO;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_fifo_readout_packer.sv
// Directed bench for adc_fifo_readout_packer: FIFO model with 1-cycle read
// latency, expected-word scoreboard and immediate-assertion checks.
module tb_adc_fifo_readout_packer;

  localparam int         FS    = 40;
  localparam int         WORDS = FS / 2;
  localparam logic [3:0] CH    = 4'd3;
  localparam int         CW    = 2;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, m_tready;
  logic          fifo_not_empty, fifo_rd_en;
  logic [11:0]   fifo_dout;
  logic [31:0]   m_tdata;
  logic          m_tvalid, m_tlast, busy, frame_done;
  logic [CW-1:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];
  int obs_rd = 0;

  always #5 clk = ~clk;

  adc_fifo_readout_packer #(
    .DATA_WIDTH(12), .CH_ID(CH), .FRAME_SAMPLES(FS), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fifo_not_empty(fifo_not_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  // FIFO model: write side owned by the stimulus, read side by this block.
  logic [11:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_not_empty = (wp != rp);
  always @(posedge clk) begin
    if (fifo_rd_en && (wp != rp)) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 1;
    end
  end

  // Output monitor, sampled mid-cycle away from the active edge.
  logic [31:0] obs_data [0:255];
  logic        obs_last [0:255];
  int obs_n = 0, rd_cnt = 0, rd_bad = 0, fd_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready && obs_n < 256) begin
        obs_data[obs_n] = m_tdata;
        obs_last[obs_n] = m_tlast;
        obs_n++;
      end
      if (fifo_rd_en) rd_cnt++;
      if (fifo_rd_en && !fifo_not_empty) rd_bad++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] smp(input int i);
    return 12'((i * 733 + 91) % 4096);
  endfunction

  function automatic logic [31:0] mk(input int k, input logic [11:0] hi, input logic [11:0] lo);
    logic [3:0] s;
    s = k[3:0];
    return {CH, s, hi, lo};
  endfunction

  task automatic push_sample(input logic [11:0] v);
    mem[wp] = v;
    wp++;
  endtask

  // Push word k's two samples (optionally paced) and its expected packed word.
  task automatic load_words(input int base, input int k0, input int k1, input int gap);
    logic [11:0] lo, hi;
    for (int k = k0; k < k1; k++) begin
      lo = smp(base + 2 * k);
      hi = smp(base + 2 * k + 1);
      push_sample(lo);
      repeat (gap) tick();
      push_sample(hi);
      repeat (gap) tick();
      exp_q.push_back('{mk(k, hi, lo), (k == WORDS - 1)});
    end
  endtask

  task automatic drain();
    exp_t e;
    int b;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      b = 0;
      while (obs_n <= obs_rd && b < 3000) begin
        tick();
        b++;
      end
      if (obs_n <= obs_rd) begin
        check("word_timeout", 32'(obs_n), 32'(obs_rd + 1));
        exp_q.delete();
      end else begin
        check($sformatf("word%0d_data", obs_rd), obs_data[obs_rd], e.data);
        check($sformatf("word%0d_last", obs_rd), 32'(obs_last[obs_rd]), 32'(e.last));
        obs_rd++;
      end
    end
  endtask

  task automatic wait_valid();
    int b;
    b = 0;
    while (!m_tvalid && b < 200) begin
      tick();
      b++;
    end
    check("tvalid_seen", 32'(m_tvalid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},  32'(fifo_rd_en),  32'd0);
    check({tag, "_tvalid"}, 32'(m_tvalid),    32'd0);
    check({tag, "_tlast"},  32'(m_tlast),     32'd0);
    check({tag, "_tdata"},  m_tdata,          32'd0);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_done"},   32'(frame_done),  32'd0);
    check({tag, "_count"},  32'(frame_count), 32'd0);
  endtask

  initial begin
    int rd0, obs0, b;
    logic [11:0] lo, hi;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_tready = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Preloaded pairs, full-rate readout.
    rd0 = rd_cnt;
    push_sample(12'h001); push_sample(12'h002);
    push_sample(12'h003); push_sample(12'h004);
    exp_q.push_back('{32'h3000_2001, 1'b0});
    exp_q.push_back('{32'h3100_4003, 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    drain();
    tick(); tick();
    check("preload_reads", 32'(rd_cnt - rd0), 32'd4);

    // Starved FIFO: no reads while empty, then one sample every 5 clk.
    repeat (10) tick();
    check("starved_reads", 32'(rd_cnt - rd0), 32'd4);
    check("starved_busy", 32'(busy), 32'd1);
    load_words(0, 2, WORDS, 5);
    drain();
    tick(); tick();
    check("f1_done_pulses", 32'(fd_cnt), 32'd1);
    check("f1_count", 32'(frame_count), 32'd1);

    // Backpressure: word 0 held for 7 clk with data still waiting in the FIFO.
    m_tready = 1'b0;
    load_words(1000, 0, WORDS, 0);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    rd0 = rd_cnt;
    for (int i = 0; i < 7; i++) begin
      check("stall_tvalid", 32'(m_tvalid), 32'd1);
      check("stall_tdata", m_tdata, exp_q[0].data);
      check("stall_tlast", 32'(m_tlast), 32'd0);
      check("stall_reads", 32'(rd_cnt), 32'(rd0));
      tick();
    end
    m_tready = 1'b1;
    drain();
    tick(); tick();
    check("f2_done_pulses", 32'(fd_cnt), 32'd2);
    check("f2_count", 32'(frame_count), 32'd2);

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // Abort in CAP_HI of word 0: pair discarded, nothing emitted.
    obs0 = obs_n; rd0 = rd_cnt;
    push_sample(12'h0AA); push_sample(12'h0BB);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("capabort_busy", 32'(busy), 32'd0);
    check("capabort_tvalid", 32'(m_tvalid), 32'd0);
    repeat (5) tick();
    check("capabort_words", 32'(obs_n), 32'(obs0));
    check("capabort_reads", 32'(rd_cnt - rd0), 32'd2);
    check("capabort_count", 32'(frame_count), 32'd2);

    // Abort in SEND of word 0: word delivered with tlast forced, no frame_done.
    m_tready = 1'b0;
    lo = 12'h5A5; hi = 12'hA5A;
    push_sample(lo); push_sample(hi);
    w = mk(0, hi, lo);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    abort = 1'b1; tick(); abort = 1'b0;
    check("sendabort_tvalid", 32'(m_tvalid), 32'd1);
    check("sendabort_tlast", 32'(m_tlast), 32'd1);
    check("sendabort_tdata", m_tdata, w);
    exp_q.push_back('{w, 1'b1});
    m_tready = 1'b1;
    drain();
    tick(); tick();
    check("sendabort_busy", 32'(busy), 32'd0);
    check("sendabort_done", 32'(fd_cnt), 32'd2);
    check("sendabort_count", 32'(frame_count), 32'd2);

    // Reset mid-frame with a word pending.
    m_tready = 1'b0;
    push_sample(12'h111); push_sample(12'h222);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    rst = 1'b1; tick();
    check_all_zero("midreset");
    rst = 1'b0; m_tready = 1'b1;
    tick();

    // Five back-to-back frames with random backpressure and stray starts.
    for (int f = 0; f < 5; f++) load_words(2000 + 100 * f, 0, WORDS, 0);
    for (int f = 0; f < 5; f++) begin
      start = 1'b1; tick(); start = 1'b0;
      b = 0;
      while (!frame_done && b < 2000) begin
        m_tready = ($urandom_range(0, 3) != 0);
        start = ((b % 37) == 5);
        tick();
        b++;
      end
      start = 1'b0; m_tready = 1'b1;
      check($sformatf("bb%0d_done", f), 32'(frame_done), 32'd1);
      check($sformatf("bb%0d_count", f), 32'(frame_count), 32'((f + 1) % 4));
      check($sformatf("bb%0d_idle", f), 32'(busy), 32'd0);
    end
    drain();
    repeat (10) tick();
    check("no_extra_words", 32'(obs_n), 32'(obs_rd));
    check("final_idle", 32'(busy), 32'd0);
    check("rd_while_empty", 32'(rd_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
